// File: rtl/llsc_monitor.sv
// LL/SC link monitor: tracks one word-granular reservation; optional LLSC_TIMEOUT_EN self-clears stale links.
// Latency: SC result pulses one cycle after the accepted SC. Backpressure: i_stall holds all request-driven state.
// Snoop and eret clears are ungated by i_valid/i_stall; no output backpressure exists.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module llsc_monitor #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_LSB       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    input  logic                   i_stall,
    input  logic                   i_lladdr_wr,
    input  logic                   i_is_sc,
    input  logic                   i_is_sw,
    input  logic [31:0]            i_wr_reg_val,
    input  logic                   i_snoop_inv,
    input  logic [`ADDR_WIDTH-1:0] i_snoop_addr,
    input  logic                   i_eret,
    output logic                   o_sc_valid,
    output logic                   o_sc_success,
    output logic                   o_link_valid,
    output logic [`ADDR_WIDTH-1:0] o_link_addr
);

    localparam int AW = `ADDR_WIDTH;

    localparam logic [0:0] UNLINKED = 1'b0;
    localparam logic [0:0] LINKED   = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [AW-1:0] addr_nxt;
    logic [AW-1:0] wr_addr;
    logic          accept;
    logic          do_sc;
    logic          do_ll;
    logic          linked;
    logic          sc_ok;
    logic          sw_clr;
    logic          snoop_clr;
    logic          tmo_clr;
    logic          link_clr;

    function automatic logic addr_match(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return a[AW-1:ADDR_LSB] == b[AW-1:ADDR_LSB];
    endfunction

    assign wr_addr   = i_wr_reg_val[AW-1:0];
    assign accept    = i_valid & ~i_stall;
    assign linked    = (state == LINKED);
    // SC outranks LL, so an illegal LL+SC pair never forms a new link
    assign do_sc     = accept & i_is_sc;
    assign do_ll     = accept & i_lladdr_wr & ~i_is_sc;
    assign sc_ok     = linked & addr_match(o_link_addr, wr_addr);
    assign sw_clr    = accept & i_is_sw & linked & addr_match(o_link_addr, wr_addr);
    assign snoop_clr = i_snoop_inv & linked & addr_match(o_link_addr, i_snoop_addr);
    assign link_clr  = sw_clr | snoop_clr | i_eret | tmo_clr;

`ifdef LLSC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] tmo_cnt;

    assign tmo_clr = linked & (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (do_ll || state_nxt != LINKED) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_clr = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        addr_nxt  = o_link_addr;
        if (do_sc) begin
            state_nxt = UNLINKED;
        end else if (do_ll) begin
            state_nxt = LINKED;
            addr_nxt  = wr_addr;
        end else if (link_clr) begin
            state_nxt = UNLINKED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= UNLINKED;
            o_link_addr  <= '0;
            o_sc_valid   <= 1'b0;
            o_sc_success <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_link_addr  <= addr_nxt;
            o_sc_valid   <= do_sc;
            o_sc_success <= do_sc & sc_ok;
        end
    end

    assign o_link_valid = linked;

endmodule

// File: tb/tb_llsc_monitor.sv
// Scoreboard bench for llsc_monitor: SC results queued at drive time, popped when o_sc_valid pulses.
`timescale 1ns/1ps
module tb_llsc_monitor;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_stall;
    logic        i_lladdr_wr;
    logic        i_is_sc;
    logic        i_is_sw;
    logic [31:0] i_wr_reg_val;
    logic        i_snoop_inv;
    logic [31:0] i_snoop_addr;
    logic        i_eret;
    logic        o_sc_valid;
    logic        o_sc_success;
    logic        o_link_valid;
    logic [31:0] o_link_addr;

    int vectors;
    int miscompares;
    logic exp_q[$];

    llsc_monitor #(.TIMEOUT_CYCLES(4), .ADDR_LSB(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .i_stall      (i_stall),
        .i_lladdr_wr  (i_lladdr_wr),
        .i_is_sc      (i_is_sc),
        .i_is_sw      (i_is_sw),
        .i_wr_reg_val (i_wr_reg_val),
        .i_snoop_inv  (i_snoop_inv),
        .i_snoop_addr (i_snoop_addr),
        .i_eret       (i_eret),
        .o_sc_valid   (o_sc_valid),
        .o_sc_success (o_sc_success),
        .o_link_valid (o_link_valid),
        .o_link_addr  (o_link_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // SC result monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n && o_sc_valid) begin
            if (exp_q.size() == 0) begin
                check("sc_spurious", 32'(o_sc_valid), 32'd0);
            end else begin
                check("sc_success", 32'(o_sc_success), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_stall = 0; i_lladdr_wr = 0; i_is_sc = 0; i_is_sw = 0;
        i_wr_reg_val = 0; i_snoop_inv = 0; i_snoop_addr = 0; i_eret = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic ll(input logic [31:0] a);
        i_valid = 1; i_lladdr_wr = 1; i_wr_reg_val = a;
        cyc();
        idle_inputs();
    endtask

    task automatic sw(input logic [31:0] a);
        i_valid = 1; i_is_sw = 1; i_wr_reg_val = a;
        cyc();
        idle_inputs();
    endtask

    task automatic sc(input logic [31:0] a, input logic exp);
        i_valid = 1; i_is_sc = 1; i_wr_reg_val = a;
        exp_q.push_back(exp);
        cyc();
        idle_inputs();
    endtask

    task automatic snoop(input logic [31:0] a);
        i_snoop_inv = 1; i_snoop_addr = a;
        cyc();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        idle_inputs();
        rst_n = 0;
        #1;
        check("rst_link_valid", 32'(o_link_valid), 32'd0);
        check("rst_link_addr", o_link_addr, 32'd0);
        check("rst_sc_valid", 32'(o_sc_valid), 32'd0);
        check("rst_sc_success", 32'(o_sc_success), 32'd0);
        idle(2);
        rst_n = 1;

        // first edge after reset release evaluates the LL
        ll(32'h100);
        check("ll_link_valid", 32'(o_link_valid), 32'd1);
        check("ll_link_addr", o_link_addr, 32'h100);
        idle(3);
        sc(32'h100, 1'b1);
        check("sc_unlink", 32'(o_link_valid), 32'd0);
        check("addr_held", o_link_addr, 32'h100);

        ll(32'h100);
        sw(32'h102);
        check("sw_same_word_clr", 32'(o_link_valid), 32'd0);
        sc(32'h100, 1'b0);
        ll(32'h100);
        sw(32'h104);
        check("sw_other_word", 32'(o_link_valid), 32'd1);
        sc(32'h100, 1'b1);

        // stalled LL must not link or load the address
        i_valid = 1; i_lladdr_wr = 1; i_wr_reg_val = 32'h200; i_stall = 1;
        cyc();
        check("stall1_link", 32'(o_link_valid), 32'd0);
        cyc();
        check("stall2_addr", o_link_addr, 32'h100);
        i_stall = 0;
        cyc();
        idle_inputs();
        check("unstall_link", 32'(o_link_valid), 32'd1);
        check("unstall_addr", o_link_addr, 32'h200);
        // stalled SC produces no result and keeps the link
        i_valid = 1; i_is_sc = 1; i_wr_reg_val = 32'h200; i_stall = 1;
        cyc();
        idle_inputs();
        check("stall_sc_link", 32'(o_link_valid), 32'd1);
        sc(32'h203, 1'b1);
        sc(32'h200, 1'b0);

        i_valid = 1; i_lladdr_wr = 1; i_wr_reg_val = 32'h300;
        i_snoop_inv = 1; i_snoop_addr = 32'h300;
        cyc();
        idle_inputs();
        check("ll_snoop_same", 32'(o_link_valid), 32'd1);
        snoop(32'h304);
        check("snoop_miss", 32'(o_link_valid), 32'd1);
        snoop(32'h300);
        check("snoop_hit", 32'(o_link_valid), 32'd0);
        ll(32'h300);
        i_eret = 1;
        cyc();
        idle_inputs();
        check("eret_clr", 32'(o_link_valid), 32'd0);

        // SC with a same-cycle matching snoop still sees the pre-edge link
        ll(32'h400);
        i_snoop_inv = 1; i_snoop_addr = 32'h400;
        sc(32'h400, 1'b1);
        check("sc_snoop_unlink", 32'(o_link_valid), 32'd0);

        ll(32'h500);
        i_lladdr_wr = 1;
        sc(32'h600, 1'b0);
        check("llsc_no_link", 32'(o_link_valid), 32'd0);
        check("llsc_addr", o_link_addr, 32'h500);

        ll(32'h700);
        i_is_sw = 1;
        sc(32'h700, 1'b1);

`ifdef LLSC_TIMEOUT_EN
        ll(32'h900);
        idle(2);
        sc(32'h900, 1'b1);
        ll(32'h900);
        idle(4);
        check("tmo_clr", 32'(o_link_valid), 32'd0);
        sc(32'h900, 1'b0);
`else
        ll(32'h900);
        idle(40);
        check("no_tmo_link", 32'(o_link_valid), 32'd1);
        sc(32'h900, 1'b1);
`endif

        // reset while an SC result is on the outputs drops it
        ll(32'h800);
        i_valid = 1; i_is_sc = 1; i_wr_reg_val = 32'h800;
        cyc();
        idle_inputs();
        rst_n = 0;
        #1;
        check("rst_drop_sc", 32'(o_sc_valid), 32'd0);
        check("rst_drop_addr", o_link_addr, 32'd0);
        check("rst_drop_link", 32'(o_link_valid), 32'd0);
        idle(2);
        rst_n = 1;
        idle(3);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/llsc_monitor.md
LLSC_MONITOR -- requirements
Module: llsc_monitor

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, number of cycles a link survives in LINKED before self-clearing; used only with LLSC_TIMEOUT_EN.
REQ-002 Parameter ADDR_LSB, default 2, lowest address bit used in link address comparisons; word granularity.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_valid  input  1  EX-stage llsc request qualifier; the other inputs are ignored when low.
REQ-006 i_stall  input  1  pipeline stall; a request is accepted only when i_valid=1 and i_stall=0.
REQ-007 i_lladdr_wr  input  1  LL executing; capture link address.
REQ-008 i_is_sc  input  1  SC executing; evaluate link.
REQ-009 i_is_sw  input  1  SW executing; possible link conflict.
REQ-010 i_wr_reg_val  input  32  effective address, zero-extended from `ADDR_WIDTH.
REQ-011 i_snoop_inv  input  1  external write notification, for example DMA or another core.
REQ-012 i_snoop_addr  input  `ADDR_WIDTH  address of the external write.
REQ-013 i_eret  input  1  exception return or context switch; clears the link.
REQ-014 o_sc_valid  output  1  one-cycle pulse carrying an SC result.
REQ-015 o_sc_success  output  1  SC outcome; meaningful only while o_sc_valid=1.
REQ-016 o_link_valid  output  1  current state is LINKED.
REQ-017 o_link_addr  output  `ADDR_WIDTH  held link address.

Function
REQ-018 FSM has two states, UNLINKED and LINKED; o_link_valid SHALL equal (state==LINKED).
REQ-019 Accepted means i_valid & ~i_stall; no state change SHALL occur on unaccepted cycles.
REQ-020 Match means equality of address bits [`ADDR_WIDTH-1:ADDR_LSB]; bits below ADDR_LSB are ignored.
REQ-021 Accepted LL SHALL load o_link_addr <= i_wr_reg_val[`ADDR_WIDTH-1:0] and enter LINKED, from either state.
REQ-022 Accepted SC SHALL evaluate success = LINKED & match(o_link_addr, i_wr_reg_val) using the pre-edge state.
REQ-023 On the next edge after an accepted SC: o_sc_valid=1, o_sc_success=success, FSM -> UNLINKED (latency 1).
REQ-024 o_sc_valid SHALL be high for exactly one cycle per accepted SC and low otherwise.
REQ-025 Accepted SW with match while LINKED SHALL clear the link; SW without match SHALL leave the link unchanged.
REQ-026 i_snoop_inv with match while LINKED SHALL clear the link; it is not gated by i_valid or i_stall.
REQ-027 i_eret=1 SHALL force UNLINKED on the next edge.
REQ-028 Priority in one cycle, highest first: SC, then LL, then (SW clear | snoop clear | eret clear).
REQ-029 LL and a matching snoop in the same cycle: LL wins and the FSM ends LINKED.
REQ-030 SC and a matching snoop in the same cycle: SC evaluates with pre-edge state, so it can still succeed; FSM ends UNLINKED.
REQ-031 i_lladdr_wr and i_is_sc both set is illegal; SC takes precedence and no new link is formed.
REQ-032 A combined accepted SW+SC: SC handling only.
REQ-033 o_link_addr SHALL hold its value after the link clears; it is updated only by an LL.

Reset
REQ-034 rst_n low SHALL immediately force state=UNLINKED, o_link_addr=0, o_sc_valid=0, o_sc_success=0, and timeout counter=0.
REQ-035 Reset during a pending SC result SHALL drop the pulse; no SC result is produced after reset.
REQ-036 The first accepted request SHALL be evaluated on the first rising edge after rst_n deasserts.

Configuration
REQ-037 Macro LLSC_TIMEOUT_EN defined: a counter of width $clog2(TIMEOUT_CYCLES+1) SHALL increment each cycle in LINKED and reset to 0 on LL or on leaving LINKED.
REQ-038 With LLSC_TIMEOUT_EN defined, the link SHALL clear on the edge where the counter reaches TIMEOUT_CYCLES-1; SC in that same cycle still evaluates pre-edge state.
REQ-039 Macro LLSC_TIMEOUT_EN undefined: no counter is built, and the link persists until an SC, a matching SW, a matching snoop, eret or reset.

Verification
REQ-040 LL 0x100, then 3 idle cycles, then SC 0x100 -> o_sc_valid pulse 1 cycle with o_sc_success=1; o_link_valid=0 afterwards.
REQ-041 LL 0x100, SW 0x102, SC 0x100 -> SW clears the link (same word); SC result 0; SW 0x104 instead -> SC result 1.
REQ-042 LL 0x200 with i_stall=1 for 2 cycles, then i_stall=0 -> link forms only on the unstalled cycle; SC 0x200 with no prior LL -> result 0.
REQ-043 LL 0x300 and i_snoop_inv 0x300 in the same cycle -> LINKED; snoop 0x300 the next cycle -> UNLINKED; i_eret while LINKED -> UNLINKED.
REQ-044 With LLSC_TIMEOUT_EN and TIMEOUT_CYCLES=4: LL, then SC on cycle 3 succeeds; LL, then SC on cycle 5 fails.
REQ-045 rst_n pulled low the cycle after an SC -> o_sc_valid=0 immediately and o_link_addr=0.
